// File: rtl/accum_pkg.sv
// Shared encodings for the burst accumulator: FSM state codes and the
// bit positions of the result flags inside Out_Flags.
package accum_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_ACCUM = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;

  // Out_Flags = {Carry, Ovf, Neg, Zero}
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_CARRY = 3;
  localparam int FLAG_W     = 4;

endpackage

// File: rtl/add32_flags.sv
// Purely combinational 32-bit adder (carry-in fixed at 0) reporting the
// unsigned carry-out and two's-complement overflow of the addition.
module add32_flags (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Sum,
  output logic        Cout,
  output logic        Ovf
);

  logic [32:0] sum_ext;

  // 33-bit add exposes the carry; overflow when like-signed operands give an opposite-signed sum
  always_comb begin
    sum_ext = {1'b0, A} + {1'b0, B};
    Sum     = sum_ext[31:0];
    Cout    = sum_ext[32];
    Ovf     = (A[31] == B[31]) && (sum_ext[31] != A[31]);
  end

endmodule

// File: rtl/accumulator_32bit.sv
// Burst accumulator: Start loads an operand count, the block then sums that
// many accepted operands and presents the result with sticky carry/overflow
// plus sign/zero flags until the consumer handshakes it away.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for Start; Len sampled and clamped to MAX_LEN
//   ST_ACCUM | In_Ready high; each accepted operand adds and decrements count
//   ST_DONE  | Out_Valid high with a frozen result until Out_Ready
module accumulator_32bit
  import accum_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [LEN_W-1:0]  Len,
  input  logic [31:0]       In_Data,
  input  logic              In_Valid,
  output logic              In_Ready,
  output logic [31:0]       Out_Data,
  output logic [3:0]        Out_Flags,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic              Busy
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;

  logic [LEN_W-1:0]   len_clamped;
  logic [31:0]        add_sum;
  logic               add_cout;
  logic               add_ovf;
  logic               in_done;

  add32_flags u_add (
    .A    (acc_q),
    .B    (In_Data),
    .Sum  (add_sum),
    .Cout (add_cout),
    .Ovf  (add_ovf)
  );

  // Oversized burst requests saturate at MAX_LEN rather than wrapping
  always_comb begin
    len_clamped = (Len > MAX_LEN_L) ? MAX_LEN_L : Len;
  end

  // Next-state and datapath update for the burst sequencer
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          acc_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          count_d = len_clamped;
          state_d = (len_clamped == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (In_Valid) begin
          acc_d   = add_sum;
          carry_d = carry_q | add_cout;
          ovf_d   = ovf_q | add_ovf;
          count_d = count_q - ONE_L;
          if (count_q == ONE_L) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Start is deliberately not looked at here, even alongside the handshake
        if (Out_Ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and accumulator registers; reset discards any partial burst
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake and result outputs decode only registered state
  always_comb begin
    in_done   = (state_q == ST_DONE);
    In_Ready  = (state_q == ST_ACCUM);
    Busy      = (state_q != ST_IDLE);
    Out_Valid = in_done;
    Out_Data  = in_done ? acc_q : 32'd0;
    Out_Flags = '0;
    if (in_done) begin
      Out_Flags[FLAG_CARRY] = carry_q;
      Out_Flags[FLAG_OVF]   = ovf_q;
      Out_Flags[FLAG_NEG]   = acc_q[31];
      Out_Flags[FLAG_ZERO]  = (acc_q == 32'd0);
    end
  end

endmodule

// File: tb/tb_accumulator_32bit.sv
// Directed bench for accumulator_32bit: stimulus pushes the hand-computed
// result of each burst into a scoreboard queue, a monitor pops and compares
// on every output handshake and checks result stability while stalled.
module tb_accumulator_32bit;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic [4:0]  Len;
  logic [31:0] In_Data;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] Out_Data;
  logic [3:0]  Out_Flags;
  logic        Out_Valid;
  logic        Out_Ready;
  logic        Busy;

  int n_vec;
  int n_err;
  int cyc;

  logic [35:0] sb_q[$];

  accumulator_32bit #(.MAX_LEN(16), .LEN_W(5)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .Len       (Len),
    .In_Data   (In_Data),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Out_Data  (Out_Data),
    .Out_Flags (Out_Flags),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Busy      (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard compare on handshake, stability while stalled
  logic        prev_stall;
  logic        prev_ov;
  logic        prev_hs;
  logic [31:0] prev_data;
  logic [3:0]  prev_flags;
  logic [35:0] exp_item;

  initial begin
    prev_stall = 1'b0;
    prev_ov    = 1'b0;
    prev_hs    = 1'b0;
    prev_data  = '0;
    prev_flags = '0;
  end

  always @(negedge Clk) begin
    if (!Rst_n) begin
      prev_stall = 1'b0;
      prev_ov    = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_stall && Out_Valid) begin
        check("stall_data_stable", 64'(Out_Data), 64'(prev_data));
        check("stall_flags_stable", 64'(Out_Flags), 64'(prev_flags));
      end
      if (Out_Valid && (!prev_ov || prev_hs)) begin
        check("out_valid_expected", 64'(sb_q.size() > 0), 64'(1));
      end
      if (Out_Valid && Out_Ready) begin
        if (sb_q.size() == 0) begin
          check("handshake_with_empty_scoreboard", 64'(0), 64'(1));
        end else begin
          exp_item = sb_q.pop_front();
          check("result_data", 64'(Out_Data), 64'(exp_item[35:4]));
          check("result_flags", 64'(Out_Flags), 64'(exp_item[3:0]));
        end
      end
      prev_stall = Out_Valid && !Out_Ready;
      prev_ov    = Out_Valid;
      prev_hs    = Out_Valid && Out_Ready;
      prev_data  = Out_Data;
      prev_flags = Out_Flags;
    end
  end

  // Inputs change 1 time unit after the rising edge
  task automatic do_start(input logic [4:0] len, input logic [31:0] exp_data, input logic [3:0] exp_flags);
    sb_q.push_back({exp_data, exp_flags});
    Start = 1'b1;
    Len   = len;
    @(posedge Clk); #1;
    Start = 1'b0;
    Len   = '0;
  endtask

  task automatic send(input logic [31:0] data, input int gap);
    logic rdy;
    logic acc;
    acc = 1'b0;
    In_Valid = 1'b1;
    In_Data  = data;
    for (int t = 0; t < 50; t++) begin
      rdy = In_Ready;
      @(posedge Clk); #1;
      if (rdy) begin
        acc = 1'b1;
        break;
      end
    end
    In_Valid = 1'b0;
    In_Data  = '0;
    check("operand_accepted", 64'(acc), 64'(1));
    repeat (gap) begin @(posedge Clk); #1; end
  endtask

  task automatic collect(input int stall, input logic start_too);
    int t;
    t = 0;
    while (!Out_Valid && t < 100) begin
      @(posedge Clk); #1;
      t++;
    end
    check("out_valid_seen", 64'(Out_Valid), 64'(1));
    repeat (stall) begin @(posedge Clk); #1; end
    Out_Ready = 1'b1;
    Start     = start_too;
    Len       = 5'd1;
    @(posedge Clk); #1;
    Out_Ready = 1'b0;
    Start     = 1'b0;
    Len       = '0;
    check("out_valid_drops", 64'(Out_Valid), 64'(0));
    check("idle_after_handshake", 64'(Busy), 64'(0));
  endtask

  task automatic check_quiet(input string name);
    check({name, "_in_ready"}, 64'(In_Ready), 64'(0));
    check({name, "_busy"}, 64'(Busy), 64'(0));
    check({name, "_out_valid"}, 64'(Out_Valid), 64'(0));
    check({name, "_out_data"}, 64'(Out_Data), 64'(0));
    check({name, "_out_flags"}, 64'(Out_Flags), 64'(0));
  endtask

  int c0;

  initial begin
    n_vec     = 0;
    n_err     = 0;
    cyc       = 0;
    Rst_n     = 1'b0;
    Start     = 1'b0;
    Len       = '0;
    In_Data   = '0;
    In_Valid  = 1'b0;
    Out_Ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_quiet("reset");
    Rst_n = 1'b1;

    // Len=3, 1+2+3 back-to-back
    do_start(5'd3, 32'd6, 4'b0000);
    check("first_in_ready_latency", 64'(In_Ready), 64'(1));
    c0 = cyc;
    send(32'd1, 0);
    send(32'd2, 0);
    check("no_early_out_valid", 64'(Out_Valid), 64'(0));
    send(32'd3, 0);
    check("throughput_cycles", 64'(cyc - c0), 64'(3));
    check("out_valid_after_last", 64'(Out_Valid), 64'(1));
    collect(0, 1'b0);

    // Carry wrap to zero
    do_start(5'd2, 32'd0, 4'b1001);
    send(32'hFFFF_FFFF, 0);
    send(32'h0000_0001, 0);
    collect(1, 1'b0);

    // Signed overflow to negative
    do_start(5'd2, 32'h8000_0000, 4'b0110);
    send(32'h7FFF_FFFF, 0);
    send(32'h0000_0001, 0);
    collect(0, 1'b0);

    // Sticky carry/overflow survive later operands
    do_start(5'd3, 32'd5, 4'b1100);
    send(32'h8000_0000, 0);
    send(32'h8000_0000, 0);
    send(32'd5, 0);
    collect(0, 1'b0);

    // Gapped operands, stray Start mid-burst, 5-cycle stall, Start on handshake
    do_start(5'd4, 32'd100, 4'b0000);
    send(32'd10, 1);
    send(32'd20, 0);
    Start = 1'b1;
    Len   = 5'd1;
    @(posedge Clk); #1;
    Start = 1'b0;
    Len   = '0;
    check("start_ignored_in_accum", 64'(In_Ready), 64'(1));
    send(32'd30, 1);
    send(32'd40, 0);
    collect(5, 1'b1);
    repeat (3) begin @(posedge Clk); #1; end
    check("start_ignored_at_handshake", 64'(Busy), 64'(0));

    // Len=0: result on the very next cycle
    do_start(5'd0, 32'd0, 4'b0001);
    check("len0_out_valid", 64'(Out_Valid), 64'(1));
    collect(0, 1'b0);

    // Len=31 clamps to 16 operands: 1..16 sums to 136
    do_start(5'd31, 32'd136, 4'b0000);
    for (int i = 1; i <= 16; i++) send(32'(i), 0);
    check("clamp_in_ready_off", 64'(In_Ready), 64'(0));
    check("clamp_done", 64'(Out_Valid), 64'(1));
    collect(0, 1'b0);

    // Reset after 2 of 5 operands; partial sum never appears
    sb_q.push_back({32'd0, 4'b0000});
    Start = 1'b1;
    Len   = 5'd5;
    @(posedge Clk); #1;
    Start = 1'b0;
    void'(sb_q.pop_back());
    send(32'd100, 0);
    send(32'd200, 0);
    Rst_n = 1'b0;
    #1;
    check_quiet("mid_burst_reset");
    #1;
    Rst_n = 1'b1;
    do_start(5'd1, 32'd7, 4'b0000);
    check("post_reset_start", 64'(In_Ready), 64'(1));
    send(32'd7, 0);
    collect(2, 1'b0);

    repeat (4) begin @(posedge Clk); #1; end
    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
